// File: rtl/shift_logic_unit_pkg.sv
// Shared op-code and FSM state encodings for the shift/logic unit.
package shift_logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_SRA  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(op_e o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_logic_unit_bitwise.sv
// Combinational WIDTH-bit AND/OR/NAND/NOR/XOR, one bit slice per generate lane.
module bitwise_logic_module
  import shift_logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  op_e op_s;
  assign op_s = op_e'(op);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    always_comb begin
      y[i] = 1'b0;
      case (op_s)
        OP_AND:  y[i] = a[i] & b[i];
        OP_OR:   y[i] = a[i] | b[i];
        OP_NAND: y[i] = ~(a[i] & b[i]);
        OP_NOR:  y[i] = ~(a[i] | b[i]);
        OP_XOR:  y[i] = a[i] ^ b[i];
        default: y[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/shift_logic_unit.sv
// Registered logic ops (one cycle) and iterative shifts (one bit per cycle)
// under a start/busy/done handshake.
module shift_logic_unit
  import shift_logic_unit_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  state_e             state, state_nxt;
  op_e                op_in, op_q;
  logic [WIDTH-1:0]   acc, acc_sh, logic_y;
  logic [SHAMT_W-1:0] cnt;

  assign op_in = op_e'(op);

  bitwise_logic_module #(.WIDTH(WIDTH)) u_bitwise (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (logic_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = is_shift(op_in) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-bit step; large shamt simply saturates to zero or sign fill.
  always_comb begin
    acc_sh = acc;
    case (op_q)
      OP_SLL:  acc_sh = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_sh = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_sh = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_sh = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= OP_AND;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_shift(op_in)) begin
              acc  <= a;
              cnt  <= shamt;
              op_q <= op_in;
            end else begin
              result <= logic_y;
            end
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            acc <= acc_sh;
            cnt <= cnt - SHAMT_W'(1);
          end else begin
            result <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign zero = (result == '0);

endmodule

// File: tb/tb_shift_logic_unit.sv
// Vector table plus hand sequences; a done-driven scoreboard checks result and timing.
module tb_shift_logic_unit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] op;
  logic [3:0] a, b;
  logic [2:0] shamt;
  logic       busy, done, zero;
  logic [3:0] result;

  shift_logic_unit #(.WIDTH(4), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [3:0] res; int cyc; } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("sb_result", 32'(result), 32'(mon_e.res));
        chk("sb_done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b;
    logic [2:0] shamt;
    logic [3:0] exp;
    logic       exp_zero;
  } vec_t;

  // Called at a negedge (cycle t): drive a request and optionally expect its done.
  task automatic launch(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb,
                        input logic [2:0] sh, input logic [3:0] exp, input bit expect_done);
    sb_t e;
    op = o; a = va; b = vb; shamt = sh; start = 1'b1;
    if (expect_done) begin
      e.res = exp;
      e.cyc = cyc + ((o >= 3'd5) ? (2 + int'(sh)) : 1);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk({name, "_timeout"}, 32'(busy), 0);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb,
                       input logic [2:0] sh, input logic [3:0] exp);
    launch(o, va, vb, sh, exp, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_idle("do_op");
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3'd2, 4'b0011, 4'b0101, 3'd0, 4'b1110, 1'b0};
    vecs[1]  = '{3'd0, 4'b0011, 4'b0101, 3'd5, 4'b0001, 1'b0};
    vecs[2]  = '{3'd1, 4'b0011, 4'b0101, 3'd0, 4'b0111, 1'b0};
    vecs[3]  = '{3'd3, 4'b0011, 4'b0101, 3'd0, 4'b1000, 1'b0};
    vecs[4]  = '{3'd4, 4'b0011, 4'b0101, 3'd0, 4'b0110, 1'b0};
    vecs[5]  = '{3'd4, 4'b1111, 4'b1111, 3'd0, 4'b0000, 1'b1};
    vecs[6]  = '{3'd3, 4'b1100, 4'b1010, 3'd0, 4'b0001, 1'b0};
    vecs[7]  = '{3'd5, 4'b1011, 4'b0110, 3'd2, 4'b1100, 1'b0};
    vecs[8]  = '{3'd7, 4'b1000, 4'b0000, 3'd6, 4'b1111, 1'b0};
    vecs[9]  = '{3'd6, 4'b1000, 4'b1111, 3'd6, 4'b0000, 1'b1};
    vecs[10] = '{3'd6, 4'b1010, 4'b0101, 3'd0, 4'b1010, 1'b0};
    vecs[11] = '{3'd7, 4'b1010, 4'b0000, 3'd1, 4'b1101, 1'b0};
    vecs[12] = '{3'd7, 4'b0110, 4'b0000, 3'd1, 4'b0011, 1'b0};
    vecs[13] = '{3'd5, 4'b0001, 4'b1001, 3'd7, 4'b0000, 1'b1};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Logic op handshake: done at t+1, idle at t+2
    launch(3'd2, 4'b0011, 4'b0101, 3'd0, 4'b1110, 1'b1);
    @(negedge clk); start = 1'b0;
    chk("nand_done_t1", 32'(done), 1);
    chk("nand_res_t1", 32'(result), 32'hE);
    @(negedge clk);
    chk("nand_busy_t2", 32'(busy), 0);
    chk("nand_done_t2", 32'(done), 0);

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt, vecs[i].exp);
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
    end

    // SLL busy/done profile across t+1..t+5
    launch(3'd5, 4'b1011, 4'b0000, 3'd2, 4'b1100, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); start = 1'b0;
      chk($sformatf("sll_busy_t%0d", k), 32'(busy), (k <= 4) ? 1 : 0);
      chk($sformatf("sll_done_t%0d", k), 32'(done), (k == 4) ? 1 : 0);
    end

    // Start while shifting is ignored
    launch(3'd5, 4'b0001, 4'b0000, 3'd3, 4'b1000, 1'b1);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    launch(3'd4, 4'b1111, 4'b0000, 3'd0, 4'b0000, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_idle("busy_ignore");
    chk("busy_ignore_result", 32'(result), 32'h8);

    // Reset mid-shift: idle, cleared, no done
    launch(3'd6, 4'b1111, 4'b0000, 3'd3, 4'b0000, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_done", 32'(done), 0);

    // Reset wins over a simultaneous start
    launch(3'd0, 4'b1111, 4'b1111, 3'd0, 4'b1111, 1'b0);
    @(negedge clk);
    chk("rst_vs_start_busy", 32'(busy), 0);
    chk("rst_vs_start_result", 32'(result), 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    // start held high: OR of zeros, done every second cycle
    launch(3'd1, 4'b0000, 4'b0000, 3'd0, 4'b0000, 1'b1);
    for (int k = 1; k < 4; k++) begin
      mon_e.res = 4'b0000;
      mon_e.cyc = cyc + 1 + 2 * k;
      sbq.push_back(mon_e);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("held_zero_t%0d", k), 32'(zero), 1);
      chk($sformatf("held_done_t%0d", k), 32'(done), (k % 2 == 1) ? 1 : 0);
      if (k == 7) start = 1'b0;
    end
    wait_idle("held");
    repeat (3) @(negedge clk);

    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
